// File: rtl/vga_sprite_compositor.sv
// Parametrised 640x480 VGA timing generator with per-frame latched, priority-composited sprites and sticky collision flags.
// Optional macro COLLISION_IRQ_EN adds a one-clk coll_irq pulse on any new collision bit.
module vga_sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 12,
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_w,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_h,
  input  logic [NUM_SPRITES*12-1:0]      sprite_color,
  input  logic [NUM_SPRITES-1:0]         sprite_en,
  input  logic [11:0]                    bg_color,
  input  logic                           coll_clear,
  output logic [COORD_W-1:0]             pix_x,
  output logic [COORD_W-1:0]             pix_y,
  output logic                           hSync,
  output logic                           vSync,
  output logic [3:0]                     VGA_R,
  output logic [3:0]                     VGA_G,
  output logic [3:0]                     VGA_B,
  output logic                           screen_end,
  output logic [NUM_SPRITES-2:0]         collision,
  output logic [15:0]                    frame_count
`ifdef COLLISION_IRQ_EN
  ,
  output logic                           coll_irq
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]   div_cnt;
  logic               pix_ce;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_end, v_end, frame_end;

  logic [COORD_W-1:0] sh_x [NUM_SPRITES];
  logic [COORD_W-1:0] sh_y [NUM_SPRITES];
  logic [COORD_W-1:0] sh_w [NUM_SPRITES];
  logic [COORD_W-1:0] sh_h [NUM_SPRITES];
  logic [11:0]        sh_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_en;

  logic [NUM_SPRITES-1:0] hit;
  logic [NUM_SPRITES-2:0] coll_set;
  logic               active_c, hsync_c, vsync_c;
  logic [11:0]        pix_color, color_q;

  // Free-running down-counter; the terminal count is the pixel enable.
  assign pix_ce = (div_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_cnt <= '0;
    else if (pix_ce) div_cnt <= DIV_W'(CLK_DIV - 1);
    else div_cnt <= div_cnt - 1'b1;
  end

  assign h_end     = (h_cnt == COORD_W'(H_TOTAL - 1));
  assign v_end     = (v_cnt == COORD_W'(V_TOTAL - 1));
  assign frame_end = pix_ce && h_end && v_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign pix_x = h_cnt;
  assign pix_y = v_cnt;

  // Shadows change only at the frame boundary so game logic never tears a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        sh_x[k] <= '0;
        sh_y[k] <= '0;
        sh_w[k] <= '0;
        sh_h[k] <= '0;
        sh_c[k] <= '0;
      end
      sh_en <= '0;
    end else if (frame_end) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        sh_x[k] <= sprite_x[k*COORD_W +: COORD_W];
        sh_y[k] <= sprite_y[k*COORD_W +: COORD_W];
        sh_w[k] <= sprite_w[k*COORD_W +: COORD_W];
        sh_h[k] <= sprite_h[k*COORD_W +: COORD_W];
        sh_c[k] <= sprite_color[k*12 +: 12];
      end
      sh_en <= sprite_en;
    end
  end

  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_hit
    logic [COORD_W:0]   x_right;
    logic [COORD_W-1:0] top;
    logic               in_x, in_y, on_screen;

    // Right edge carries an extra bit so sprites near the coordinate limit do not wrap.
    assign x_right   = {1'b0, sh_x[k]} + {1'b0, sh_w[k]} - 1'b1;
    assign top       = (sh_h[k] > sh_y[k]) ? '0 : sh_y[k] - sh_h[k] + 1'b1;
    assign in_x      = (h_cnt >= sh_x[k]) && ({1'b0, h_cnt} <= x_right);
    assign in_y      = (v_cnt >= top) && (v_cnt <= sh_y[k]);
    assign on_screen = (sh_x[k] < COORD_W'(H_ACTIVE)) && (top < COORD_W'(V_ACTIVE));
    assign hit[k]    = sh_en[k] && (sh_w[k] != '0) && (sh_h[k] != '0) &&
                       in_x && in_y && on_screen;
  end

  assign active_c = (h_cnt < COORD_W'(H_ACTIVE)) && (v_cnt < COORD_W'(V_ACTIVE));
  assign hsync_c  = !((h_cnt >= COORD_W'(HS_START)) && (h_cnt <= COORD_W'(HS_END)));
  assign vsync_c  = !((v_cnt >= COORD_W'(VS_START)) && (v_cnt <= COORD_W'(VS_END)));

  // Walk from the highest index down so the lowest-index hit wins.
  always_comb begin
    pix_color = bg_color;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (hit[k]) pix_color = sh_c[k];
    end
    if (!active_c) pix_color = '0;
  end

  for (genvar k = 1; k < NUM_SPRITES; k++) begin : g_coll
    assign coll_set[k-1] = active_c && hit[0] && hit[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_q <= '0;
      hSync   <= 1'b1;
      vSync   <= 1'b1;
    end else if (pix_ce) begin
      color_q <= pix_color;
      hSync   <= hsync_c;
      vSync   <= vsync_c;
    end
  end

  assign VGA_R = color_q[11:8];
  assign VGA_G = color_q[7:4];
  assign VGA_B = color_q[3:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      screen_end  <= 1'b0;
      frame_count <= '0;
    end else begin
      screen_end <= frame_end;
      if (frame_end) frame_count <= frame_count + 16'd1;
    end
  end

  // Clear has priority; a coincident set reappears on the next overlapping pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) collision <= '0;
    else if (coll_clear) collision <= '0;
    else if (pix_ce) collision <= collision | coll_set;
  end

`ifdef COLLISION_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) coll_irq <= 1'b0;
    else coll_irq <= !coll_clear && pix_ce && (|(coll_set & ~collision));
  end
`endif

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor on a shrunken 24x18 raster (16x12 active, CLK_DIV=2).
module tb_vga_sprite_compositor;
  localparam int NS = 4;
  localparam int CW = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS*CW-1:0] sprite_x, sprite_y, sprite_w, sprite_h;
  logic [NS*12-1:0] sprite_color;
  logic [NS-1:0]    sprite_en;
  logic [11:0]      bg_color;
  logic             coll_clear;
  logic [CW-1:0]    pix_x, pix_y;
  logic             hSync, vSync;
  logic [3:0]       VGA_R, VGA_G, VGA_B;
  logic             screen_end;
  logic [NS-2:0]    collision;
  logic [15:0]      frame_count;
`ifdef COLLISION_IRQ_EN
  logic             coll_irq;
  int               irq_cnt = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0, t1, t2, n0;

  vga_sprite_compositor #(
    .NUM_SPRITES(NS), .COORD_W(CW), .CLK_DIV(2),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .reset(reset),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_w(sprite_w), .sprite_h(sprite_h),
    .sprite_color(sprite_color), .sprite_en(sprite_en), .bg_color(bg_color),
    .coll_clear(coll_clear), .pix_x(pix_x), .pix_y(pix_y),
    .hSync(hSync), .vSync(vSync), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .screen_end(screen_end), .collision(collision), .frame_count(frame_count)
`ifdef COLLISION_IRQ_EN
    , .coll_irq(coll_irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
`ifdef COLLISION_IRQ_EN
  always @(negedge clk) if (coll_irq) irq_cnt++;
`endif

  // Background encodes its own coordinate so any latency error shows up.
  assign bg_color = {4'h1, pix_y[3:0], pix_x[3:0]};

  function automatic logic [11:0] rgb();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs for pixel (x,y) are visible while the counters sit at (x+1,y).
  task automatic at_pixel(input int x, input int y);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (pix_x == CW'(x + 1) && pix_y == CW'(y)) found = 1'b1;
    end
    chk($sformatf("reach_%0d_%0d", x, y), {31'd0, found}, 32'd1);
  endtask

  task automatic wait_screen_end(output int t);
    bit found;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (screen_end) begin
        found = 1'b1;
        t = cyc;
      end
    end
    chk("screen_end_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    coll_clear = 1'b1;
    @(negedge clk);
    coll_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    coll_clear = 1'b0;
    sprite_en = 4'b1111;
    sprite_x[0 +: 12] = 3;  sprite_y[0 +: 12] = 8;  sprite_w[0 +: 12] = 4; sprite_h[0 +: 12] = 5;
    sprite_x[12 +: 12] = 5; sprite_y[12 +: 12] = 8; sprite_w[12 +: 12] = 4; sprite_h[12 +: 12] = 2;
    sprite_x[24 +: 12] = 12; sprite_y[24 +: 12] = 2; sprite_w[24 +: 12] = 2; sprite_h[24 +: 12] = 20;
    sprite_x[36 +: 12] = 0; sprite_y[36 +: 12] = 11; sprite_w[36 +: 12] = 0; sprite_h[36 +: 12] = 12;
    sprite_color = {12'hFFF, 12'h0A0, 12'hC13, 12'hC10};

    repeat (3) @(negedge clk);
    chk("rst_hsync", hSync, 1);
    chk("rst_vsync", vSync, 1);
    chk("rst_color", rgb(), 12'h000);
    chk("rst_screen_end", screen_end, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_collision", collision, 0);
    chk("rst_pix", {pix_y, pix_x}, 0);

    reset = 1'b1;
    c0 = cyc;
    begin : hs_wait
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (!hSync) seen = 1'b1;
      end
      chk("hsync_fall_seen", {31'd0, seen}, 32'd1);
      chk("hsync_fall_delay", cyc - (c0 + 1), 36);
    end

    at_pixel(4, 5);
    chk("f0_bg", rgb(), 12'h154);

    wait_screen_end(t1);
    chk("f0_frame_count", frame_count, 1);
    @(negedge clk);
    chk("screen_end_width", screen_end, 0);

    at_pixel(12, 0);  chk("s2_top_clamp", rgb(), 12'h0A0);
    at_pixel(12, 2);  chk("s2_bottom", rgb(), 12'h0A0);
    at_pixel(3, 3);   chk("s0_above", rgb(), 12'h133);
    at_pixel(18, 3);  chk("hsync_low", hSync, 0);
    at_pixel(21, 3);  chk("hsync_high", hSync, 1);
    at_pixel(6, 4);   chk("s0_top_right", rgb(), 12'hC10);
    at_pixel(16, 5);  chk("blank_h", rgb(), 12'h000);
    at_pixel(8, 6);   chk("s1_above", rgb(), 12'h168);
    chk("coll_before", collision, 0);
    at_pixel(5, 7);   chk("overlap_prio", rgb(), 12'hC10);
    chk("coll_set", collision, 3'b001);
    at_pixel(2, 8);   chk("s0_left_out", rgb(), 12'h182);
    at_pixel(3, 8);   chk("s0_left_in", rgb(), 12'hC10);
    at_pixel(8, 8);   chk("s1_right_in", rgb(), 12'hC13);
    at_pixel(9, 8);   chk("s1_right_out", rgb(), 12'h189);
    at_pixel(0, 11);  chk("s3_w0", rgb(), 12'h1B0);
    chk("coll_only_s1", collision, 3'b001);
    at_pixel(0, 13);  chk("vsync_pre", vSync, 1);
    at_pixel(0, 14);  chk("vsync_low", vSync, 0);
    chk("blank_v", rgb(), 12'h000);
    at_pixel(18, 15); chk("both_sync_low", {hSync, vSync}, 2'b00);
    at_pixel(0, 16);  chk("vsync_post", vSync, 1);

    wait_screen_end(t2);
    chk("frame_period", t2 - t1, 864);
    chk("f1_frame_count", frame_count, 2);

    pulse_clear();
    chk("coll_cleared", collision, 0);
`ifdef COLLISION_IRQ_EN
    n0 = irq_cnt;
`endif
    at_pixel(5, 7);
    chk("coll_reassert", collision, 3'b001);
    at_pixel(0, 11);
`ifdef COLLISION_IRQ_EN
    chk("irq_single_pulse", irq_cnt - n0, 1);
`endif

    wait_screen_end(t1);
    at_pixel(0, 5);
    sprite_x[0 +: 12] = 10;
    at_pixel(3, 8);   chk("move_old_pos", rgb(), 12'hC10);
    at_pixel(10, 8);  chk("move_new_not_yet", rgb(), 12'h18A);
    at_pixel(0, 11);
    pulse_clear();
    chk("coll_cleared2", collision, 0);

    wait_screen_end(t2);
    chk("f3_frame_count", frame_count, 4);
    at_pixel(3, 8);   chk("moved_old_gone", rgb(), 12'h183);
    at_pixel(10, 8);  chk("moved_new_pos", rgb(), 12'hC10);
    at_pixel(0, 11);  chk("no_coll_after_move", collision, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
